// File: rtl/manchester_frame_serializer.sv
// Frames a word (start, MSB-first data, optional even parity, stop bits) for the Manchester encoder.
// Latency: START begins on the first bit-clock fall after acceptance; one-word holding register deasserts tx_ready while full.
module manchester_frame_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  bit_clock,
    output logic                  ser_data,
    output logic                  ser_enable,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(HALF);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_nxt;
    logic                  fall_stb;

    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic                  load;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  parity_q;
    logic                  parity_nxt;
    logic                  data_nxt;
    logic                  en_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;

    assign fall_stb = (div_cnt == DIV_LAST);
    assign div_nxt  = fall_stb ? '0 : div_cnt + DIV_W'(1);
    assign tx_ready = ~hold_full;

    // bit_clock is derived from the next count so it falls on the edge after fall_stb
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            bit_clock <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            bit_clock <= (div_nxt >= DIV_HALF);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_dat  <= '0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_dat  <= tx_data;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            ser_data   <= 1'b0;
            ser_enable <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            shift_q    <= shift_nxt;
            parity_q   <= parity_nxt;
            ser_data   <= data_nxt;
            ser_enable <= en_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    // Outputs are computed for the state being entered, so they change only on fall_stb edges
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = bit_cnt;
        shift_nxt  = shift_q;
        parity_nxt = parity_q;
        data_nxt   = ser_data;
        en_nxt     = ser_enable;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        load       = 1'b0;
        if (fall_stb) begin
            case (state)
                IDLE: begin
                    load = hold_full;
                end
                START: begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    data_nxt  = shift_q[DATA_WIDTH-1];
                    shift_nxt = shift_q << 1;
                end
                DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        cnt_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            data_nxt  = parity_q;
                        end else begin
                            state_nxt = STOP;
                            data_nxt  = 1'b0;
                            en_nxt    = 1'b0;
                        end
                    end else begin
                        cnt_nxt   = bit_cnt + CNT_W'(1);
                        data_nxt  = shift_q[DATA_WIDTH-1];
                        shift_nxt = shift_q << 1;
                    end
                end
                PARITY: begin
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                    data_nxt  = 1'b0;
                    en_nxt    = 1'b0;
                end
                STOP: begin
                    if (bit_cnt == STOP_LAST) begin
                        done_nxt = 1'b1;
                        cnt_nxt  = '0;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    data_nxt  = 1'b0;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
            if (load) begin
                state_nxt  = START;
                shift_nxt  = hold_dat;
                parity_nxt = ^hold_dat;
                data_nxt   = 1'b1;
                en_nxt     = 1'b1;
                busy_nxt   = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_manchester_frame_serializer.sv
// Bench for manchester_frame_serializer: frame-level reference model plus directed scenarios.
module tb_manchester_frame_serializer;
    localparam int DW        = 8;
    localparam int CD        = 4;
    localparam int PE        = 1;
    localparam int SB        = 2;
    localparam int FRAME_LEN = 1 + DW + PE + SB;
    localparam int EN_LEN    = 1 + DW + PE;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, bit_clock, ser_data, ser_enable, busy, frame_done;

    manchester_frame_serializer #(
        .DATA_WIDTH(DW), .CLK_DIV(CD), .PARITY_EN(PE), .STOP_BITS(SB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .bit_clock(bit_clock), .ser_data(ser_data),
        .ser_enable(ser_enable), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Value of frame bit period p for word w: start, MSB-first data, parity, stops.
    function automatic logic frame_bit(input logic [DW-1:0] w, input int p);
        if (p == 0) return 1'b1;
        if (p >= 1 && p <= DW) return w[DW-p];
        if (PE != 0 && p == DW + 1) return ^w;
        return 1'b0;
    endfunction

    // Reference model: phase within the bit period, one holding slot, index of the current bit period.
    int            m_div  = 0;
    int            m_pos  = -1;
    logic          m_hold_v = 1'b0;
    logic [DW-1:0] m_hold_w = '0;
    logic [DW-1:0] m_word   = '0;
    logic          m_bc = 1'b0, m_sd = 1'b0, m_en = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic          m_live = 1'b0;

    always @(posedge clock) begin : model
        logic acc, fall, start;
        if (!reset_n) begin
            m_live = 1'b1; m_div = 0; m_pos = -1; m_hold_v = 1'b0; m_hold_w = '0; m_word = '0;
            m_bc = 1'b0; m_sd = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_live) begin
            acc   = tx_valid && !m_hold_v;
            fall  = (m_div == CD - 1);
            m_div = (m_div + 1) % CD;
            m_bc  = (m_div >= CD / 2);
            m_done = 1'b0;
            start  = 1'b0;
            if (fall) begin
                if (m_pos < 0) start = m_hold_v;
                else if (m_pos == FRAME_LEN - 1) begin
                    m_done = 1'b1; m_pos = -1; start = m_hold_v;
                end else m_pos++;
                if (start) begin
                    m_word = m_hold_w; m_hold_v = 1'b0; m_pos = 0;
                end
                m_busy = (m_pos >= 0);
                m_en   = (m_pos >= 0) && (m_pos < EN_LEN);
                m_sd   = (m_pos >= 0) ? frame_bit(m_word, m_pos) : 1'b0;
            end
            if (acc) begin
                m_hold_v = 1'b1; m_hold_w = tx_data;
            end
        end
    end

    logic                p_bc = 1'b0, p_sd = 1'b0;
    int                  done_cnt = 0;
    int                  nbits = 0;
    logic [EN_LEN-1:0]   acc_bits = '0;
    logic [DW-1:0]       got_w[$];
    logic                got_p[$];

    always @(posedge clock) begin : cmp
        #1;
        if (m_live) begin
            chk("tx_ready",   32'(tx_ready),   32'(!m_hold_v));
            chk("bit_clock",  32'(bit_clock),  32'(m_bc));
            chk("ser_data",   32'(ser_data),   32'(m_sd));
            chk("ser_enable", 32'(ser_enable), 32'(m_en));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            if (!reset_n) begin
                nbits = 0;
            end else begin
                if (ser_data !== p_sd) chk("sd_on_fall", 32'({p_bc, bit_clock}), 32'd2);
                if (p_bc && !bit_clock && ser_enable) begin
                    acc_bits = {acc_bits[EN_LEN-2:0], ser_data};
                    nbits++;
                    if (nbits == EN_LEN) begin
                        chk("start_bit", 32'(acc_bits[EN_LEN-1]), 32'd1);
                        got_w.push_back(acc_bits[DW:1]);
                        got_p.push_back(acc_bits[0]);
                        nbits = 0;
                    end
                end
                if (frame_done) done_cnt++;
            end
            p_bc = bit_clock;
            p_sd = ser_data;
        end
    end

    task automatic send(input logic [DW-1:0] w, input logic keep);
        int t = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && t < 300) begin @(negedge clock); t++; end
        chk("accept_timeout", 32'(t < 300), 32'd1);
        @(negedge clock);
        chk("ready_low_after_accept", 32'(tx_ready), 32'd0);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (done_cnt < target && n < 500) begin @(negedge clock); n++; end
        chk("frames_reached", 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin : stim
        logic          bc_pat[8];
        logic [DW-1:0] exp_w[8];
        logic          exp_p[8];
        logic [11:0]   a5_bits;
        int            n, bcyc, ecyc, dcyc;

        bc_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_w  = '{8'hA5, 8'hFF, 8'h01, 8'h12, 8'h07, 8'h80, 8'hC3, 8'h5A};
        exp_p  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        for (int p = 0; p < FRAME_LEN; p++) a5_bits[11-p] = frame_bit(8'hA5, p);
        chk("model_a5_bits", 32'(a5_bits), 32'h0D28);

        // Reset with tx_valid high: nothing may be accepted.
        reset_n  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_tx_ready",   32'(tx_ready),   32'd1);
        chk("rst_bit_clock",  32'(bit_clock),  32'd0);
        chk("rst_ser_data",   32'(ser_data),   32'd0);
        chk("rst_ser_enable", 32'(ser_enable), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("bc_pattern", 32'(bit_clock), 32'(bc_pat[i]));
        end

        // Single frame timing.
        send(8'hA5, 1'b0);
        n = 0;
        while (!busy && n < 20) begin @(negedge clock); n++; end
        chk("a5_start_seen", 32'(n < 20), 32'd1);
        bcyc = 0; ecyc = 0; dcyc = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            if (ser_enable) ecyc++;
            if (frame_done) dcyc++;
            @(negedge clock);
        end
        chk("a5_busy_cycles",  32'(bcyc), 32'd48);
        chk("a5_en_cycles",    32'(ecyc), 32'd40);
        chk("a5_done_early",   32'(dcyc), 32'd0);
        chk("a5_done_at_end",  32'(frame_done), 32'd1);
        @(negedge clock);
        chk("a5_done_one_cyc", 32'(frame_done), 32'd0);

        // Back-to-back with second word presented during DATA.
        send(8'hFF, 1'b0);
        repeat (10) @(negedge clock);
        chk("ready_in_data", 32'(tx_ready), 32'd1);
        send(8'h01, 1'b0);
        n = 0;
        while (!frame_done && n < 200) begin @(negedge clock); n++; end
        chk("b2b_done_seen", 32'(n < 200), 32'd1);
        chk("b2b_gap_en",    32'(ser_enable), 32'd1);
        chk("b2b_gap_sd",    32'(ser_data),   32'd1);
        wait_frames(3);

        // Backpressure: tx_valid held high across three words.
        send(8'h12, 1'b1);
        send(8'h07, 1'b1);
        send(8'h80, 1'b0);
        wait_frames(6);
        repeat (4) @(negedge clock);

        // Reset during data bit 3; the frame is abandoned.
        send(8'h3C, 1'b0);
        n = 0;
        while (!busy && n < 20) begin @(negedge clock); n++; end
        repeat (17) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_enable", 32'(ser_enable), 32'd0);
        chk("midrst_busy",   32'(busy),       32'd0);
        chk("midrst_done",   32'(frame_done), 32'd0);
        chk("midrst_ready",  32'(tx_ready),   32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (60) @(negedge clock);
        chk("midrst_no_done", 32'(done_cnt), 32'd6);

        send(8'hC3, 1'b0);
        wait_frames(7);
        repeat (4) @(negedge clock);

        // Acceptance on a fall_stb edge: START waits a full bit period.
        n = 0;
        while (m_div != CD - 1 && n < 10) begin @(negedge clock); n++; end
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        chk("fall_acc_ready", 32'(tx_ready), 32'd0);
        n = 0;
        while (!busy && n < 20) begin @(negedge clock); n++; end
        chk("fall_acc_latency", 32'(n), 32'd4);
        wait_frames(8);
        repeat (8) @(negedge clock);

        chk("frames_decoded", 32'(got_w.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_w.size(); i++) begin
            chk("word_order", 32'(got_w[i]), 32'(exp_w[i]));
            chk("parity_bit", 32'(got_p[i]), 32'(exp_p[i]));
        end
        chk("done_total", 32'(done_cnt), 32'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/manchester_frame_serializer.md
Name: manchester_frame_serializer

Overview:
- Frames a parallel trigger word and serialises it, one bit per bit period, for the downstream Manchester encoder.
- Generates the encoder's bit clock from the system clock.
- Drives the encoder's data and enable inputs so that every data transition coincides with a falling edge of the bit clock.
- Sits directly upstream of the Manchester encoder in the AMIGA trigger transmit path.

Parameters:
- DATA_WIDTH, 16: payload bits per frame.
- CLK_DIV, 4: system clocks per bit period; even, >= 2. HALF = CLK_DIV/2.
- PARITY_EN, 1: 1 appends an even-parity bit after the payload; 0 omits it.
- STOP_BITS, 2: idle bit periods after each frame; >= 1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty; a word is accepted when tx_valid && tx_ready.
- bit_clock  out  1  50% duty bit clock, period CLK_DIV; feeds the encoder clock.
- ser_data  out  1  serial bit; feeds the encoder data input.
- ser_enable  out  1  1 during start/data/parity bits; feeds the encoder enable.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset values (reset_n=0 at a rising edge): div_cnt=0, bit_clock=0, ser_data=0, ser_enable=0, busy=0, frame_done=0, tx_ready=1, holding register empty, FSM=IDLE.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, wraps, and free-runs.
  - fall_stb = (div_cnt == CLK_DIV-1).
  - bit_clock is registered: 0 when the next div_cnt < HALF, else 1.
  - Hence bit_clock falls on the edge following fall_stb.
- Alignment: bit_clock, ser_data, ser_enable, busy and frame_done are all registered. They update only on the fall_stb edge (except bit_clock's rising edge), so data never changes while bit_clock is high.
- Input handshake:
  - Acceptance latches tx_data into the holding register.
  - tx_ready goes 0 on the same edge and returns to 1 on the edge where the holding register is moved into the shift register.
  - Holding depth is 1. An accepted word is never dropped or overwritten.
- FSM states: IDLE, START, DATA, PARITY, STOP. Transitions are evaluated only on fall_stb edges.
  - IDLE: ser_data=0, ser_enable=0, busy=0. If the holding register is full, go to START, load the shift register from holding, and compute parity = XOR of the word. A word accepted on the fall_stb edge itself waits for the next fall_stb.
  - START: one bit period; ser_data=1, ser_enable=1, busy=1.
  - DATA: DATA_WIDTH bit periods, MSB first; ser_enable=1.
  - PARITY (only if PARITY_EN): one bit period; ser_data=parity, ser_enable=1.
  - STOP: STOP_BITS bit periods; ser_data=0, ser_enable=0, busy=1.
  - End of the last stop bit: frame_done=1 for exactly one cycle. If the holding register is full, go directly to START on the same edge (no extra gap); otherwise go to IDLE with busy=0.
- Frame length: 1 + DATA_WIDTH + PARITY_EN + STOP_BITS bit periods, i.e. that many times CLK_DIV clocks.
- Bit counter: width clog2(DATA_WIDTH+1). It counts data bits and stop bits. It does not wrap within a state.
- tx_valid deasserting while tx_ready=0 has no effect. tx_data is sampled only at acceptance.
- Reset mid-frame: all state returns to reset values on the reset edge, the frame is abandoned, no frame_done is issued, and the held word is discarded.

Test Plan:
(DATA_WIDTH=8, CLK_DIV=4, PARITY_EN=1, STOP_BITS=2)
- Reset: hold reset_n=0 for 3 clocks with tx_valid=1.
  -> All outputs at reset values, tx_ready=1, nothing accepted.
  -> After release, bit_clock toggles with period 4, low for 2 clocks then high for 2.
- Single word 8'hA5.
  -> ser_data per bit period: 1,1,0,1,0,0,1,0,1, then parity 0, then stop 0,0.
  -> ser_enable=1 for 10 bit periods (40 clocks); busy=1 for 48 clocks.
  -> frame_done pulses once, 48 clocks after START begins.
  -> Every ser_data change coincides with the bit_clock 1->0 edge.
- Back-to-back: send 8'hFF, then 8'h01 presented during the first frame's DATA state.
  -> 8'h01 is accepted immediately (tx_ready=1 after load).
  -> Second START follows the first frame's last stop bit with zero gap.
  -> Parity bits are 0 then 1; frame_done pulses twice.
- Backpressure: present 3 words with tx_valid held high.
  -> tx_ready=0 between loads; all 3 frames transmitted in order, none lost or duplicated.
- Reset mid-frame: assert reset_n=0 during data bit 3 of 8'h3C.
  -> ser_enable=0 and busy=0 on the next edge; no frame_done.
  -> A subsequent 8'hC3 frame is transmitted correctly.
- Acceptance on a fall_stb cycle.
  -> START begins exactly CLK_DIV clocks later, not on the same edge.
